// File: rtl/ysyx_22050019_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC,
// bus response codes and the PC alignment helper.
package ysyx_22050019_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Instructions are 4-byte aligned; the low two target bits carry no meaning.
    function automatic logic [63:0] align_pc(input logic [63:0] target);
        return {target[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch: one outstanding 64-bit read per instruction, word picked by pc[2].
// Latency: 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD); no prefetch.
// Backpressure: HOLD keeps inst_* stable until out_ready; a redirect squashes or flushes.
module ysyx_22050019_ifu
    import ysyx_22050019_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          BUS_W    = 64
) (
    input  logic             clk,
    input  logic             rst,

    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [63:0]      ar_addr,

    input  logic             r_valid,
    output logic             r_ready,
    input  logic [BUS_W-1:0] r_data,
    input  logic [1:0]       r_resp,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      inst_addr_pc,
    output logic [31:0]      inst_o,
    output logic             inst_fault,

    input  logic             redir_valid,
    input  logic [63:0]      redir_pc
);

    ifu_state_e  state, state_nxt;
    logic [63:0] pc, pc_nxt;
    logic        flush, flush_nxt;
    logic        latch_en;

    logic        ar_hs, r_hs, out_hs;
    logic [31:0] word_sel;
    logic [63:0] redir_aligned;

    assign ar_valid  = !rst && (state == IFU_REQ);
    assign r_ready   = !rst && (state == IFU_WAIT);
    assign out_valid = !rst && (state == IFU_HOLD);
    assign ar_addr   = {pc[63:3], 3'b000};

    assign ar_hs  = ar_valid  && ar_ready;
    assign r_hs   = r_valid   && r_ready;
    assign out_hs = out_valid && out_ready;

    assign word_sel      = pc[2] ? r_data[63:32] : r_data[31:0];
    assign redir_aligned = align_pc(redir_pc);

    // A redirect always wins the PC, whatever state the fetch is in.
    always_comb begin
        pc_nxt = pc;
        if (redir_valid) begin
            pc_nxt = redir_aligned;
        end else if (out_hs) begin
            pc_nxt = pc + 64'd4;
        end
    end

    always_comb begin
        state_nxt = state;
        flush_nxt = flush;
        latch_en  = 1'b0;
        case (state)
            IFU_REQ: begin
                // An address beat accepted in the redirect cycle still carries
                // the old PC, so its data must be drained and dropped.
                if (ar_hs) begin
                    state_nxt = IFU_WAIT;
                    flush_nxt = redir_valid;
                end
            end
            IFU_WAIT: begin
                if (r_hs) begin
                    flush_nxt = 1'b0;
                    if (flush || redir_valid) begin
                        state_nxt = IFU_REQ;
                    end else begin
                        latch_en  = 1'b1;
                        state_nxt = IFU_HOLD;
                    end
                end else if (redir_valid) begin
                    flush_nxt = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (out_hs || redir_valid) begin
                    state_nxt = IFU_REQ;
                end
            end
            default: begin
                state_nxt = IFU_REQ;
                flush_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IFU_REQ;
            pc           <= RESET_PC;
            flush        <= 1'b0;
            inst_o       <= 32'd0;
            inst_fault   <= 1'b0;
            inst_addr_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            flush <= flush_nxt;
            if (latch_en) begin
                inst_o       <= word_sel;
                inst_fault   <= (r_resp != RESP_OKAY);
                inst_addr_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Bench for the fetch unit: behavioural memory slave, architectural PC scoreboard,
// vector table of redirect targets, directed corner sequences and a random phase.
module tb_ysyx_22050019_ifu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid;
    logic        ar_ready = 1'b1;
    logic [63:0] ar_addr;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [63:0] r_data = 64'd0;
    logic [1:0]  r_resp = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] inst_addr_pc;
    logic [31:0] inst_o;
    logic        inst_fault;
    logic        redir_valid = 1'b0;
    logic [63:0] redir_pc = 64'd0;

    ysyx_22050019_ifu dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .out_valid(out_valid), .out_ready(out_ready),
        .inst_addr_pc(inst_addr_pc), .inst_o(inst_o), .inst_fault(inst_fault),
        .redir_valid(redir_valid), .redir_pc(redir_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory image: two known words at the reset vector, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    logic        err_en = 1'b0;
    logic [63:0] err_addr = 64'd0;
    int          mem_delay = 0;

    function automatic logic is_err(input logic [63:0] a);
        return err_en && ({a[63:3], 3'b000} == err_addr);
    endfunction

    // Memory slave: handshakes sampled at posedge, responses driven at negedge.
    logic        s_ar_hs = 1'b0, s_r_hs = 1'b0;
    logic [63:0] s_ar_addr = 64'd0;
    logic        pend = 1'b0;
    logic [63:0] paddr = 64'd0;
    int          cnt = 0;

    always @(posedge clk) begin
        s_ar_hs   = ar_valid && ar_ready;
        s_r_hs    = r_valid && r_ready;
        s_ar_addr = ar_addr;
    end

    always @(negedge clk) begin
        if (s_r_hs) begin
            pend    = 1'b0;
            r_valid = 1'b0;
        end
        if (s_ar_hs) begin
            pend    = 1'b1;
            paddr   = s_ar_addr;
            cnt     = mem_delay;
            r_valid = 1'b0;
        end
        if (pend && !r_valid) begin
            if (cnt == 0) begin
                r_valid = 1'b1;
                r_data  = {mem_word(paddr + 64'd4), mem_word(paddr)};
                r_resp  = is_err(paddr) ? 2'b10 : 2'b00;
            end else begin
                cnt--;
            end
        end
    end

    // Architectural scoreboard: any redirect sets the PC, a delivered
    // instruction otherwise advances it by 4; every delivery must match it.
    logic [63:0] model_pc = RST_PC;
    int          cyc = 0;
    int          hs_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          last_hs_cyc = 0, prev_hs_cyc = 0;
    logic [63:0] last_pc = 64'd0, last_ar_addr = 64'd0;
    logic [31:0] last_inst = 32'd0;
    logic        last_fault = 1'b0;
    logic        ov_seen = 1'b0;
    logic        hold_chk = 1'b0;
    logic [63:0] h_pc = 64'd0;
    logic [31:0] h_inst = 32'd0;
    logic        h_fault = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            model_pc = RST_PC;
            hold_chk = 1'b0;
        end else begin
            chk("ar_r_exclusive", 64'(ar_valid && r_ready), 64'd0);
            if (hold_chk) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_inst", 64'(inst_o), 64'(h_inst));
                chk("hold_pc", inst_addr_pc, h_pc);
                chk("hold_fault", 64'(inst_fault), 64'(h_fault));
            end
            if (ar_valid && ar_ready) begin
                ar_cnt++;
                last_ar_addr = ar_addr;
            end
            if (r_valid && r_ready) r_cnt++;
            if (out_valid) ov_seen = 1'b1;
            if (out_valid && out_ready) begin
                chk("deliver_pc", inst_addr_pc, model_pc);
                chk("deliver_inst", 64'(inst_o), 64'(mem_word(model_pc)));
                chk("deliver_fault", 64'(inst_fault), 64'(is_err(model_pc)));
                hs_cnt++;
                prev_hs_cyc = last_hs_cyc;
                last_hs_cyc = cyc;
                last_pc     = inst_addr_pc;
                last_inst   = inst_o;
                last_fault  = inst_fault;
            end
            hold_chk = out_valid && !out_ready && !redir_valid;
            h_pc     = inst_addr_pc;
            h_inst   = inst_o;
            h_fault  = inst_fault;
            if (redir_valid) model_pc = {redir_pc[63:2], 2'b00};
            else if (out_valid && out_ready) model_pc = model_pc + 64'd4;
        end
    end

    task automatic wait_hs(input string nm);
        int start;
        start = hs_cnt;
        for (int i = 0; i < 300; i++) begin
            if (hs_cnt != start) break;
            @(negedge clk);
        end
        if (hs_cnt == start) begin
            checks++; errors++;
            $display("FAIL %s: no out handshake within 300 cycles", nm);
        end
    endtask

    task automatic wait_ar(input string nm);
        int start;
        start = ar_cnt;
        for (int i = 0; i < 300; i++) begin
            if (ar_cnt != start) break;
            @(negedge clk);
        end
        if (ar_cnt == start) begin
            checks++; errors++;
            $display("FAIL %s: no address handshake within 300 cycles", nm);
        end
    endtask

    task automatic wait_ov(input string nm);
        for (int i = 0; i < 300; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s: out_valid never rose within 300 cycles", nm);
        end
    endtask

    // Squash whatever is held and steer the PC to target.
    task automatic set_pc(input logic [63:0] target);
        out_ready = 1'b0;
        wait_ov("set_pc");
        redir_valid = 1'b1;
        redir_pc    = target;
        @(negedge clk);
        redir_valid = 1'b0;
    endtask

    task automatic do_reset();
        redir_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [63:0] target;
        logic        err;
        logic [63:0] pc0;
        logic [31:0] inst0;
        logic        f0;
        logic [63:0] pc1;
        logic [31:0] inst1;
        logic        f1;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int start_hs, start_r;

        vecs[0] = '{64'h8000_0000, 1'b0, 64'h8000_0000, 32'h0000_0013, 1'b0,
                    64'h8000_0004, 32'h0010_0093, 1'b0};
        vecs[1] = '{64'h8000_1000, 1'b0, 64'h8000_1000, 32'h40DE_1000, 1'b0,
                    64'h8000_1004, 32'h40DE_1004, 1'b0};
        vecs[2] = '{64'h8000_0103, 1'b0, 64'h8000_0100, 32'h40DE_0100, 1'b0,
                    64'h8000_0104, 32'h40DE_0104, 1'b0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h3F21_FFFC, 1'b0,
                    64'h0000_0000_0000_0000, 32'hC0DE_0000, 1'b0};
        vecs[4] = '{64'h8000_2004, 1'b1, 64'h8000_2004, 32'h40DE_2004, 1'b1,
                    64'h8000_2008, 32'h40DE_2008, 1'b0};
        vecs[5] = '{64'h8000_000C, 1'b0, 64'h8000_000C, 32'h40DE_000C, 1'b0,
                    64'h8000_0010, 32'h40DE_0010, 1'b0};

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        chk("rst_ar_valid", 64'(ar_valid), 64'd0);
        chk("rst_r_ready", 64'(r_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_inst_o", 64'(inst_o), 64'd0);
        chk("rst_inst_fault", 64'(inst_fault), 64'd0);
        chk("rst_inst_pc", inst_addr_pc, RST_PC);
        rst = 1'b0;
        #1;
        chk("first_ar_valid", 64'(ar_valid), 64'd1);
        chk("first_ar_addr", ar_addr, RST_PC);

        // Zero-wait fetch of the first two words, 3 cycles apart.
        out_ready = 1'b1;
        wait_hs("a_hs0");
        chk("a_inst0", 64'(last_inst), 64'h0000_0013);
        chk("a_pc0", last_pc, 64'h8000_0000);
        wait_hs("a_hs1");
        chk("a_inst1", 64'(last_inst), 64'h0010_0093);
        chk("a_pc1", last_pc, 64'h8000_0004);
        chk("a_spacing", 64'(last_hs_cyc - prev_hs_cyc), 64'd3);

        // Decode stalls 5 cycles in HOLD.
        out_ready = 1'b0;
        do_reset();
        wait_ov("b_ov");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("b_stall_valid", 64'(out_valid), 64'd1);
            chk("b_stall_inst", 64'(inst_o), 64'h0000_0013);
            chk("b_stall_pc", inst_addr_pc, 64'h8000_0000);
            chk("b_stall_no_ar", 64'(ar_valid), 64'd0);
        end
        out_ready = 1'b1;
        wait_hs("b_release");
        chk("b_next_ar_valid", 64'(ar_valid), 64'd1);
        chk("b_next_ar_addr", ar_addr, 64'h8000_0000);
        wait_hs("b_next_hs");
        chk("b_next_pc", last_pc, 64'h8000_0004);

        // Vector table: redirect to each target, then take two instructions.
        for (int v = 0; v < 6; v++) begin
            err_en   = vecs[v].err;
            err_addr = {vecs[v].target[63:3], 3'b000};
            set_pc(vecs[v].target);
            out_ready = 1'b1;
            wait_hs("v_hs0");
            chk("v_pc0", last_pc, vecs[v].pc0);
            chk("v_inst0", 64'(last_inst), 64'(vecs[v].inst0));
            chk("v_fault0", 64'(last_fault), 64'(vecs[v].f0));
            wait_hs("v_hs1");
            chk("v_pc1", last_pc, vecs[v].pc1);
            chk("v_inst1", 64'(last_inst), 64'(vecs[v].inst1));
            chk("v_fault1", 64'(last_fault), 64'(vecs[v].f1));
            chk("v_spacing", 64'(last_hs_cyc - prev_hs_cyc), 64'd3);
        end
        err_en = 1'b0;

        // Redirect while waiting on a slow read: the stale data is drained.
        mem_delay = 4;
        set_pc(64'h8000_0200);
        out_ready = 1'b1;
        wait_ar("c_ar0");
        ov_seen     = 1'b0;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_1000;
        @(negedge clk);
        redir_valid = 1'b0;
        wait_ar("c_ar1");
        chk("c_ar_addr", last_ar_addr, 64'h8000_1000);
        chk("c_no_out", 64'(ov_seen), 64'd0);
        wait_hs("c_hs");
        chk("c_pc", last_pc, 64'h8000_1000);
        chk("c_inst", 64'(last_inst), 64'h40DE_1000);

        // Redirect coinciding with the out handshake.
        mem_delay = 0;
        set_pc(64'h8000_0008);
        wait_ov("d_ov");
        chk("d_held_pc", inst_addr_pc, 64'h8000_0008);
        chk("d_held_inst", 64'(inst_o), 64'h40DE_0008);
        start_hs    = hs_cnt;
        out_ready   = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'h8000_0100;
        @(negedge clk);
        redir_valid = 1'b0;
        chk("d_hs_taken", 64'(hs_cnt - start_hs), 64'd1);
        wait_ar("d_ar");
        chk("d_ar_addr", last_ar_addr, 64'h8000_0100);
        wait_hs("d_hs");
        chk("d_pc", last_pc, 64'h8000_0100);

        // Reset while a read is outstanding; the late response must be ignored.
        mem_delay = 6;
        set_pc(64'h8000_3000);
        wait_ar("e_ar");
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        ar_ready = 1'b0;
        start_r  = r_cnt;
        ov_seen  = 1'b0;
        repeat (8) @(negedge clk);
        chk("e_no_r_hs", 64'(r_cnt - start_r), 64'd0);
        chk("e_no_out", 64'(ov_seen), 64'd0);
        chk("e_ar_valid", 64'(ar_valid), 64'd1);
        chk("e_ar_addr", ar_addr, RST_PC);
        mem_delay = 0;
        ar_ready  = 1'b1;
        out_ready = 1'b1;
        wait_hs("e_hs");
        chk("e_pc", last_pc, RST_PC);
        chk("e_inst", 64'(last_inst), 64'h0000_0013);

        // Random traffic against the scoreboard.
        err_en   = 1'b1;
        err_addr = 64'h8000_0040;
        start_hs = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            ar_ready    = ($urandom_range(0, 9) < 7);
            mem_delay   = $urandom_range(0, 3);
            out_ready   = ($urandom_range(0, 9) < 6);
            redir_valid = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 19) == 0)
                redir_pc = {$urandom, $urandom};
            else
                redir_pc = 64'h8000_0000 + 64'($urandom_range(0, 511));
            @(negedge clk);
        end
        redir_valid = 1'b0;
        chk("rand_progress", 64'(hs_cnt - start_hs > 100), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
